// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Target end of the execution unit's memory request interface. It owns a
//   word-addressed RAM and serves one read or write at a time with a fixed
//   latency. It also runs two whole-array sweeps: clear-to-zero and a
//   word-per-cycle dump stream.
//
// Ports
//   Clk, Rst_n      : clock (rising edge) and synchronous active-low reset
//   Mem_op_enable   : request strobe, only looked at in IDLE
//   Read_sig        : read qualifier
//   Write_sig       : write qualifier
//   Address_in      : request address
//   Data_in         : write data
//   Data_out        : registered read data, held until the next read completes
//   Mem_op_success  : one-cycle completion pulse
//   Mem_op_error    : one-cycle pulse for a request with both or neither qualifier
//   Mem_busy        : high whenever the responder is not IDLE
//   Read_back_sig   : start the clear sweep
//   Write_back_sig  : start the dump sweep
//   Dump_valid      : dump word valid
//   Dump_addr       : dump word address
//   Dump_data       : dump word data
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Mem_op_enable,
    input  logic              Read_sig,
    input  logic              Write_sig,
    input  logic [ADDR_W-1:0] Address_in,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              Mem_op_success,
    output logic              Mem_op_error,
    output logic              Mem_busy,
    input  logic              Read_back_sig,
    input  logic              Write_back_sig,
    output logic              Dump_valid,
    output logic [ADDR_W-1:0] Dump_addr,
    output logic [DATA_W-1:0] Dump_data
);

    localparam int         DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CLEAR,
        S_DUMP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_sweep;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_is_write;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_req_ok;
    logic                w_done;
    logic                w_sweep_last;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    // A legal request carries exactly one of the two qualifiers.
    assign w_req_ok     = Read_sig ^ Write_sig;
    assign w_done       = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_sweep_last = &r_sweep;
    assign Mem_busy     = (r_state != S_IDLE);

    // ---------------- state register ----------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Read_back_sig)                   w_next = S_CLEAR;
                else if (Write_back_sig)             w_next = S_DUMP;
                else if (Mem_op_enable && w_req_ok)  w_next = S_ACCESS;
            end
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_IDLE;
            S_CLEAR:  if (w_sweep_last)  w_next = S_IDLE;
            S_DUMP:   if (w_sweep_last)  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath / outputs ----------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_cnt          <= '0;
            r_sweep        <= '0;
            r_addr         <= '0;
            r_data         <= '0;
            r_is_write     <= 1'b0;
            Data_out       <= '0;
            Mem_op_success <= 1'b0;
            Mem_op_error   <= 1'b0;
            Dump_valid     <= 1'b0;
            Dump_addr      <= '0;
            Dump_data      <= '0;
        end else begin
            Mem_op_success <= 1'b0;
            Mem_op_error   <= 1'b0;
            Dump_valid     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Read_back_sig || Write_back_sig) begin
                        r_sweep <= '0;
                    end else if (Mem_op_enable) begin
                        r_addr     <= Address_in;
                        r_data     <= Data_in;
                        r_is_write <= Write_sig;
                        if (w_req_ok) r_cnt        <= LAT_M1;
                        else          Mem_op_error <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        Mem_op_success <= 1'b1;
                        if (!r_is_write) Data_out <= r_mem[r_addr];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CLEAR: begin
                    r_sweep <= r_sweep + 1'b1;
                end
                S_DUMP: begin
                    Dump_valid <= 1'b1;
                    Dump_addr  <= r_sweep;
                    Dump_data  <= r_mem[r_sweep];
                    r_sweep    <= r_sweep + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Single write port shared by the clear sweep and completing writes.
    // Gated by Rst_n so a write whose completion edge coincides with reset
    // is dropped; the array itself is never reset.
    assign w_mem_we    = Rst_n && ((r_state == S_CLEAR) || (w_done && r_is_write));
    assign w_mem_addr  = (r_state == S_CLEAR) ? r_sweep : r_addr;
    assign w_mem_wdata = (r_state == S_CLEAR) ? '0 : r_data;

    always_ff @(posedge Clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 256;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              Mem_op_enable;
    logic              Read_sig;
    logic              Write_sig;
    logic [ADDR_W-1:0] Address_in;
    logic [DATA_W-1:0] Data_in;
    logic [DATA_W-1:0] Data_out;
    logic              Mem_op_success;
    logic              Mem_op_error;
    logic              Mem_busy;
    logic              Read_back_sig;
    logic              Write_back_sig;
    logic              Dump_valid;
    logic [ADDR_W-1:0] Dump_addr;
    logic [DATA_W-1:0] Dump_data;

    mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Mem_op_enable(Mem_op_enable),
        .Read_sig(Read_sig), .Write_sig(Write_sig), .Address_in(Address_in),
        .Data_in(Data_in), .Data_out(Data_out), .Mem_op_success(Mem_op_success),
        .Mem_op_error(Mem_op_error), .Mem_busy(Mem_busy),
        .Read_back_sig(Read_back_sig), .Write_back_sig(Write_back_sig),
        .Dump_valid(Dump_valid), .Dump_addr(Dump_addr), .Dump_data(Dump_data)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain array of words plus the last read value.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] ref_dout;
    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One legal read or write, ending in the completion (success) cycle.
    task automatic do_op(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        Mem_op_enable = 1'b1; Read_sig = !wr; Write_sig = wr;
        Address_in = a; Data_in = d;
        step();                                  // acceptance edge
        // Scramble request inputs: they must be ignored while busy.
        Mem_op_enable = 1'($urandom); Read_sig = 1'($urandom); Write_sig = 1'($urandom);
        Address_in = ADDR_W'($urandom); Data_in = DATA_W'($urandom);
        for (int k = 0; k < LATENCY; k++) begin
            chk("op_busy", 32'(Mem_busy), 32'd1);
            chk("op_early_success", 32'(Mem_op_success), 32'd0);
            chk("op_dout_hold", 32'(Data_out), 32'(ref_dout));
            step();
        end
        Mem_op_enable = 1'b0;
        if (wr) ref_mem[a] = d;
        else    ref_dout  = ref_mem[a];
        chk("op_success", 32'(Mem_op_success), 32'd1);
        chk("op_error", 32'(Mem_op_error), 32'd0);
        chk("op_idle", 32'(Mem_busy), 32'd0);
        chk("op_dout", 32'(Data_out), 32'(ref_dout));
    endtask

    task automatic do_bad(input bit both, input logic [ADDR_W-1:0] a);
        Mem_op_enable = 1'b1; Read_sig = both; Write_sig = both;
        Address_in = a; Data_in = DATA_W'($urandom);
        step();
        Mem_op_enable = 1'b0;
        chk("bad_error", 32'(Mem_op_error), 32'd1);
        chk("bad_success", 32'(Mem_op_success), 32'd0);
        chk("bad_busy", 32'(Mem_busy), 32'd0);
        step();
        chk("bad_error_pulse", 32'(Mem_op_error), 32'd0);
        chk("bad_success2", 32'(Mem_op_success), 32'd0);
    endtask

    // Clear sweep, optionally with a simultaneous request and strobes while busy.
    task automatic do_clear(input bit with_req);
        int n;
        Read_back_sig = 1'b1;
        if (with_req) begin
            Mem_op_enable = 1'b1; Read_sig = 1'b0; Write_sig = 1'b1;
            Address_in = 8'h21; Data_in = 16'hDEAD;
        end
        step();
        Read_back_sig = 1'b0; Mem_op_enable = 1'b0;
        n = 0;
        while (Mem_busy && n < 400) begin
            n++;
            if (with_req) begin
                Mem_op_enable = 1'($urandom); Read_sig = 1'b1; Write_sig = 1'b0;
                chk("clr_no_success", 32'(Mem_op_success), 32'd0);
                chk("clr_no_error", 32'(Mem_op_error), 32'd0);
            end
            step();
        end
        Mem_op_enable = 1'b0;
        chk("clr_busy_cycles", 32'(n), 32'(DEPTH));
        chk("clr_end_success", 32'(Mem_op_success), 32'd0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic do_dump();
        int idx, n;
        Write_back_sig = 1'b1;
        step();
        Write_back_sig = 1'b0;
        chk("dump_busy", 32'(Mem_busy), 32'd1);
        chk("dump_first_valid", 32'(Dump_valid), 32'd0);
        idx = 0; n = 0;
        while (n < 300) begin
            n++;
            step();
            if (Dump_valid) begin
                chk("dump_addr", 32'(Dump_addr), 32'(idx));
                chk("dump_data", 32'(Dump_data), 32'(ref_mem[idx[ADDR_W-1:0]]));
                idx++;
            end else if (idx > 0) begin
                break;
            end
        end
        chk("dump_count", 32'(idx), 32'(DEPTH));
        chk("dump_end_busy", 32'(Mem_busy), 32'd0);
        chk("dump_hold_addr", 32'(Dump_addr), 32'(DEPTH - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst_n = 1'b0; Mem_op_enable = 1'b0; Read_sig = 1'b0; Write_sig = 1'b0;
        Address_in = '0; Data_in = '0; Read_back_sig = 1'b0; Write_back_sig = 1'b0;
        ref_dout = '0;
        step(); step();
        chk("rst_dout", 32'(Data_out), 32'd0);
        chk("rst_success", 32'(Mem_op_success), 32'd0);
        chk("rst_error", 32'(Mem_op_error), 32'd0);
        chk("rst_busy", 32'(Mem_busy), 32'd0);
        chk("rst_dvalid", 32'(Dump_valid), 32'd0);
        chk("rst_daddr", 32'(Dump_addr), 32'd0);
        chk("rst_ddata", 32'(Dump_data), 32'd0);
        Rst_n = 1'b1;
        step();

        // Clear, then spot reads
        do_clear(1'b0);
        do_op(1'b0, 8'h00, '0);
        do_op(1'b0, 8'h7F, '0);
        do_op(1'b0, 8'hFF, '0);

        // Write/read back
        do_op(1'b1, 8'h12, 16'hBEEF);
        do_op(1'b0, 8'h12, '0);
        chk("beef_value", 32'(Data_out), 32'h0000BEEF);

        // Illegal requests leave memory untouched
        do_op(1'b1, 8'h05, 16'h1234);
        do_bad(1'b1, 8'h05);
        do_bad(1'b0, 8'h05);
        do_op(1'b0, 8'h05, '0);
        chk("bad_mem_kept", 32'(Data_out), 32'h00001234);

        // Dump
        do_op(1'b1, 8'h03, 16'h00AA);
        step();
        do_dump();

        // Clear has priority over a simultaneous request; strobes while busy ignored
        do_clear(1'b1);
        do_op(1'b0, 8'h21, '0);
        chk("dropped_req", 32'(Data_out), 32'd0);

        // Reset one cycle after accepting a write aborts it
        Mem_op_enable = 1'b1; Write_sig = 1'b1; Read_sig = 1'b0;
        Address_in = 8'h40; Data_in = 16'h5555;
        step();
        Mem_op_enable = 1'b0; Write_sig = 1'b0;
        Rst_n = 1'b0;
        step();
        ref_dout = '0;
        chk("abort_dout", 32'(Data_out), 32'd0);
        chk("abort_success", 32'(Mem_op_success), 32'd0);
        chk("abort_busy", 32'(Mem_busy), 32'd0);
        chk("abort_dvalid", 32'(Dump_valid), 32'd0);
        Rst_n = 1'b1;
        step();
        chk("abort_no_success", 32'(Mem_op_success), 32'd0);
        do_op(1'b0, 8'h40, '0);
        chk("abort_mem", 32'(Data_out), 32'd0);

        // Randomized back-to-back traffic against the model
        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 4)       do_op(1'b1, ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
            else if (kind < 8)  do_op(1'b0, ADDR_W'($urandom_range(0, 15)), '0);
            else                do_bad(kind == 9, ADDR_W'($urandom));
        end
        step();
        do_dump();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
